// File: rtl/motor_pulse_to_pixel.sv
// Converts stepper X/Y pulse trains into a pen pixel position and frame-buffer writes,
// with a full-frame raster clear. States: IDLE | tracking pen, writing on moves; CLEAR | raster fill
module motor_pulse_to_pixel #(
  parameter int          PULSE_NUM_X_FACTOR = 4,
  parameter int          PULSE_NUM_Y_FACTOR = 4,
  parameter int          H_PIXELS           = 640,
  parameter int          V_PIXELS           = 480,
  parameter int          H_BITS             = 10,
  parameter int          V_BITS             = 9,
  parameter logic [7:0]  DRAW_COLOR         = 8'hFF,
  parameter logic [7:0]  TRACE_COLOR        = 8'h1C,
  parameter logic [7:0]  CLEAR_COLOR        = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              motors_signal_x,
  input  logic              motors_dir_x,
  input  logic              motors_signal_y,
  input  logic              motors_dir_y,
  input  logic              should_draw,
  input  logic              trace_path,
  input  logic              clear_screen,
  output logic              wr_en,
  output logic [H_BITS-1:0] wr_x,
  output logic [V_BITS-1:0] wr_y,
  output logic [7:0]        byte_out,
  output logic [H_BITS-1:0] px_x,
  output logic [V_BITS-1:0] px_y,
  output logic              busy
);

  localparam int SXW = (PULSE_NUM_X_FACTOR > 1) ? $clog2(PULSE_NUM_X_FACTOR) : 1;
  localparam int SYW = (PULSE_NUM_Y_FACTOR > 1) ? $clog2(PULSE_NUM_Y_FACTOR) : 1;
  localparam logic [SXW-1:0]    SX_MAX = SXW'(PULSE_NUM_X_FACTOR - 1);
  localparam logic [SYW-1:0]    SY_MAX = SYW'(PULSE_NUM_Y_FACTOR - 1);
  localparam logic [H_BITS-1:0] X_MAX  = H_BITS'(H_PIXELS - 1);
  localparam logic [V_BITS-1:0] Y_MAX  = V_BITS'(V_PIXELS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_next;

  logic              samp_x, samp_y, edge_x, edge_y, dir_x, dir_y;
  logic [SXW-1:0]    sub_x, sub_x_next;
  logic [SYW-1:0]    sub_y, sub_y_next;
  logic [H_BITS-1:0] px_x_next, cx;
  logic [V_BITS-1:0] px_y_next, cy;
  logic              moved, clr_prev, clr_trig, clr_last;
  logic              pen_wr;
  logic [H_BITS-1:0] pen_x;
  logic [V_BITS-1:0] pen_y;
  logic [7:0]        pen_byte;

  // Edge pulses last one clock; direction is captured alongside the edge it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_x <= 1'b0; samp_y <= 1'b0;
      edge_x <= 1'b0; edge_y <= 1'b0;
      dir_x  <= 1'b0; dir_y  <= 1'b0;
    end else if (clk_en) begin
      edge_x <= motors_signal_x & ~samp_x;
      edge_y <= motors_signal_y & ~samp_y;
      samp_x <= motors_signal_x;
      samp_y <= motors_signal_y;
      dir_x  <= motors_dir_x;
      dir_y  <= motors_dir_y;
    end else begin
      edge_x <= 1'b0;
      edge_y <= 1'b0;
    end
  end

  always_comb begin
    sub_x_next = sub_x;
    px_x_next  = px_x;
    if (edge_x) begin
      if (dir_x) begin
        if (sub_x != SX_MAX) sub_x_next = sub_x + 1'b1;
        else if (px_x != X_MAX) begin
          sub_x_next = '0;
          px_x_next  = px_x + 1'b1;
        end
      end else begin
        if (sub_x != '0) sub_x_next = sub_x - 1'b1;
        else if (px_x != '0) begin
          sub_x_next = SX_MAX;
          px_x_next  = px_x - 1'b1;
        end
      end
    end
  end

  always_comb begin
    sub_y_next = sub_y;
    px_y_next  = px_y;
    if (edge_y) begin
      if (dir_y) begin
        if (sub_y != SY_MAX) sub_y_next = sub_y + 1'b1;
        else if (px_y != Y_MAX) begin
          sub_y_next = '0;
          px_y_next  = px_y + 1'b1;
        end
      end else begin
        if (sub_y != '0) sub_y_next = sub_y - 1'b1;
        else if (px_y != '0) begin
          sub_y_next = SY_MAX;
          px_y_next  = px_y - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_x <= '0; sub_y <= '0;
      px_x  <= '0; px_y  <= '0;
      moved <= 1'b0;
    end else begin
      sub_x <= sub_x_next;
      sub_y <= sub_y_next;
      px_x  <= px_x_next;
      px_y  <= px_y_next;
      moved <= (px_x_next != px_x) || (px_y_next != px_y);
    end
  end

  assign clr_trig = (state == IDLE) && clear_screen && !clr_prev;
  assign clr_last = (cx == X_MAX) && (cy == Y_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_trig) state_next = CLEAR;
      CLEAR:   if (clr_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_prev <= 1'b0;
      cx       <= '0;
      cy       <= '0;
    end else begin
      clr_prev <= clear_screen;
      if (state == CLEAR && !clr_last) begin
        if (cx == X_MAX) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end else begin
        cx <= '0;
        cy <= '0;
      end
    end
  end

  // A pen write loses to a clear that is active or starting on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pen_wr   <= 1'b0;
      pen_x    <= '0;
      pen_y    <= '0;
      pen_byte <= 8'h00;
    end else begin
      pen_wr <= moved && (should_draw || trace_path) && (state == IDLE) && !clr_trig;
      if (moved) begin
        pen_x    <= px_x;
        pen_y    <= px_y;
        pen_byte <= should_draw ? DRAW_COLOR : TRACE_COLOR;
      end
    end
  end

  assign busy     = (state == CLEAR);
  assign wr_en    = busy || pen_wr;
  assign wr_x     = busy ? cx : pen_x;
  assign wr_y     = busy ? cy : pen_y;
  assign byte_out = busy ? CLEAR_COLOR : pen_byte;

endmodule

// File: tb/tb_motor_pulse_to_pixel.sv
// Randomized and directed bench for motor_pulse_to_pixel on a small frame, checked
// against an absolute pulse-position model with a queue of expected pen writes.
module tb_motor_pulse_to_pixel;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int FX = 4;
  localparam int FY = 4;
  localparam logic [7:0] DRAW  = 8'hFF;
  localparam logic [7:0] TRACE = 8'h1C;

  logic       clk, reset, clk_en;
  logic       motors_signal_x, motors_dir_x, motors_signal_y, motors_dir_y;
  logic       should_draw, trace_path, clear_screen;
  logic       wr_en, busy;
  logic [9:0] wr_x, px_x;
  logic [8:0] wr_y, px_y;
  logic [7:0] byte_out;

  motor_pulse_to_pixel #(
    .PULSE_NUM_X_FACTOR(FX), .PULSE_NUM_Y_FACTOR(FY),
    .H_PIXELS(H), .V_PIXELS(V)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .motors_signal_x(motors_signal_x), .motors_dir_x(motors_dir_x),
    .motors_signal_y(motors_signal_y), .motors_dir_y(motors_dir_y),
    .should_draw(should_draw), .trace_path(trace_path), .clear_screen(clear_screen),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .byte_out(byte_out),
    .px_x(px_x), .px_y(px_y), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int x; int y; logic [7:0] b; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0, n_fail = 0;
  int mpos_x, mpos_y;
  logic mprev_x, mprev_y, model_clear;
  int exp_cnt = 0, pen_cnt = 0, busy_cyc = 0, clr_idx = 0, clr_base = 0;
  int last_pen_x, last_pen_y, last_clr_x, last_clr_y;
  logic [7:0] last_pen_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (busy) busy_cyc++;
      if (wr_en && busy) begin
        check("clr_x", wr_x, (clr_idx - clr_base) % H);
        check("clr_y", wr_y, (clr_idx - clr_base) / H);
        check("clr_byte", byte_out, 8'h00);
        last_clr_x = wr_x;
        last_clr_y = wr_y;
        clr_idx++;
      end else if (wr_en) begin
        wr_t e;
        pen_cnt++;
        last_pen_x = wr_x;
        last_pen_y = wr_y;
        last_pen_b = byte_out;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pen_x", wr_x, e.x);
          check("pen_y", wr_y, e.y);
          check("pen_byte", byte_out, e.b);
        end
      end
    end
  end

  // Model sees what the DUT samples on the next rising edge.
  task automatic cyc(input logic sx, dx, sy, dy, en, clr);
    int ox, oy;
    wr_t w;
    @(negedge clk);
    motors_signal_x = sx; motors_dir_x = dx;
    motors_signal_y = sy; motors_dir_y = dy;
    clk_en = en; clear_screen = clr;
    if (en) begin
      ox = mpos_x / FX;
      oy = mpos_y / FY;
      if (sx && !mprev_x) mpos_x = dx ? ((mpos_x < H*FX-1) ? mpos_x + 1 : mpos_x)
                                       : ((mpos_x > 0) ? mpos_x - 1 : 0);
      if (sy && !mprev_y) mpos_y = dy ? ((mpos_y < V*FY-1) ? mpos_y + 1 : mpos_y)
                                       : ((mpos_y > 0) ? mpos_y - 1 : 0);
      mprev_x = sx;
      mprev_y = sy;
      if ((mpos_x / FX != ox || mpos_y / FY != oy) && !model_clear && (should_draw || trace_path)) begin
        w.x = mpos_x / FX;
        w.y = mpos_y / FY;
        w.b = should_draw ? DRAW : TRACE;
        exp_q.push_back(w);
        exp_cnt++;
      end
    end
  endtask

  task automatic pulse(input logic ox, dx, oy, dy);
    cyc(ox, dx, oy, dy, 1'b1, 1'b0);
    cyc(1'b0, dx, 1'b0, dy, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mpos_x = 0; mpos_y = 0; mprev_x = 1'b0; mprev_y = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic settle(input int pb, input int eb);
    idle(6);
    check("px_x", px_x, mpos_x / FX);
    check("px_y", px_y, mpos_y / FY);
    check("pen_writes", pen_cnt - pb, exp_cnt - eb);
    check("pen_q_left", exp_q.size(), 0);
  endtask

  task automatic wait_clear(input logic hold);
    logic started;
    started = 1'b0;
    for (int i = 0; i < H*V + 20; i++) begin
      @(negedge clk);
      if (!hold) clear_screen = 1'b0;
      if (busy) started = 1'b1;
      else if (started) break;
    end
    check("clr_done", busy, 1'b0);
  endtask

  task automatic rand_phase(input int n, input int bx, input int by);
    int pb, eb;
    pb = pen_cnt; eb = exp_cnt;
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 99) < bx,
          $urandom_range(0, 1), $urandom_range(0, 99) < by,
          $urandom_range(0, 3) != 0, 1'b0);
    settle(pb, eb);
  endtask

  initial begin
    int pb, eb, bb;
    reset = 1'b0; clk_en = 1'b0; clear_screen = 1'b0;
    motors_signal_x = 1'b0; motors_dir_x = 1'b0; motors_signal_y = 1'b0; motors_dir_y = 1'b0;
    should_draw = 1'b0; trace_path = 1'b0; model_clear = 1'b0;
    mpos_x = 0; mpos_y = 0; mprev_x = 1'b0; mprev_y = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_x", wr_x, 0);
    check("rst_wr_y", wr_y, 0);
    check("rst_byte", byte_out, 0);
    check("rst_px_x", px_x, 0);
    check("rst_px_y", px_y, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // four X pulses make one pixel step with a draw write
    should_draw = 1'b1;
    pb = pen_cnt; eb = exp_cnt;
    repeat (4) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    settle(pb, eb);
    check("r028_px_x", px_x, 1);
    check("r028_writes", pen_cnt - pb, 1);
    check("r028_wr_x", last_pen_x, 1);
    check("r028_wr_y", last_pen_y, 0);
    check("r028_byte", last_pen_b, 8'hFF);

    // decrement at origin clamps, sub counter stays at 0
    do_reset();
    pb = pen_cnt; eb = exp_cnt;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    settle(pb, eb);
    check("r029_px_x", px_x, 0);
    check("r029_writes", pen_cnt - pb, 0);
    repeat (4) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    settle(pb, eb);
    check("r029_sub_kept", px_x, 1);

    // pen up: moves silently; trace on: trace-colored writes
    do_reset();
    should_draw = 1'b0; trace_path = 1'b0;
    pb = pen_cnt; eb = exp_cnt;
    repeat (8) pulse(1'b0, 1'b0, 1'b1, 1'b1);
    settle(pb, eb);
    check("r030_px_y", px_y, 2);
    check("r030_writes", pen_cnt - pb, 0);
    trace_path = 1'b1;
    pb = pen_cnt; eb = exp_cnt;
    repeat (8) pulse(1'b0, 1'b0, 1'b1, 1'b1);
    settle(pb, eb);
    check("r030_px_y2", px_y, 4);
    check("r030_writes2", pen_cnt - pb, 2);
    check("r030_byte", last_pen_b, 8'h1C);

    // diagonal step: one write for both axes
    do_reset();
    should_draw = 1'b1; trace_path = 1'b0;
    pb = pen_cnt; eb = exp_cnt;
    repeat (4) pulse(1'b1, 1'b1, 1'b1, 1'b1);
    settle(pb, eb);
    check("r033_writes", pen_cnt - pb, 1);
    check("r033_wr_x", last_pen_x, 1);
    check("r033_wr_y", last_pen_y, 1);

    // random walks, including runs pushed into both clamp edges
    should_draw = 1'b0; trace_path = 1'b1;
    rand_phase(400, 50, 50);
    should_draw = 1'b1;
    rand_phase(900, 85, 85);
    should_draw = 1'b0; trace_path = 1'b0;
    rand_phase(300, 50, 50);
    should_draw = 1'b1;
    rand_phase(900, 15, 15);

    // full clear
    pb = pen_cnt; eb = exp_cnt;
    clr_base = clr_idx; bb = busy_cyc;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_clear(1'b0);
    check("clr_busy_cycles", busy_cyc - bb, H*V);
    check("clr_writes", clr_idx - clr_base, H*V);
    check("clr_last_x", last_clr_x, H-1);
    check("clr_last_y", last_clr_y, V-1);
    settle(pb, eb);

    // motion during clear is tracked but not drawn
    pb = pen_cnt; eb = exp_cnt;
    clr_base = clr_idx; bb = busy_cyc;
    model_clear = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (6) pulse(1'b1, mpos_x < FX, 1'b1, mpos_y < FY);
    wait_clear(1'b0);
    model_clear = 1'b0;
    check("r023_busy_cycles", busy_cyc - bb, H*V);
    settle(pb, eb);

    // clear_screen held high does not retrigger
    clr_base = clr_idx;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_clear(1'b1);
    bb = busy_cyc;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("no_retrigger", busy_cyc - bb, 0);
    idle(2);

    // clear trigger coinciding with a pen write wins
    do_reset();
    should_draw = 1'b1;
    repeat (3) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    pb = pen_cnt; eb = exp_cnt;
    clr_base = clr_idx; bb = busy_cyc;
    model_clear = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_clear(1'b0);
    model_clear = 1'b0;
    check("r024_busy_cycles", busy_cyc - bb, H*V);
    settle(pb, eb);
    check("r024_px_x", px_x, 1);
    check("r024_writes", pen_cnt - pb, 0);

    // reset aborts a clear in progress
    repeat (5) pulse(1'b1, 1'b1, 1'b1, 1'b1);
    idle(6);
    clr_base = clr_idx;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      clear_screen = 1'b0;
      if (clr_idx - clr_base >= 50) break;
    end
    #2 reset = 1'b0;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_wr_x", wr_x, 0);
    check("abort_wr_y", wr_y, 0);
    check("abort_byte", byte_out, 0);
    check("abort_px_x", px_x, 0);
    check("abort_px_y", px_y, 0);
    mpos_x = 0; mpos_y = 0; mprev_x = 1'b0; mprev_y = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    pb = pen_cnt; eb = exp_cnt; bb = busy_cyc;
    idle(10);
    check("abort_no_resume", busy_cyc - bb, 0);
    repeat (4) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    settle(pb, eb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
